uart_tx: RTL and testbench

UART transmitter that serializes parallel bytes onto the serial line consumed by uart_rx.
- Bit order is MSB first, matching the uart_rx receiver.
- Default timing is 115200 baud from a 100 MHz clock (868 clocks per bit).
- Upstream logic hands words in over a valid/ready handshake.
- Frame format: 1 start bit (low), BIT_NUM data bits, STOP_BITS stop bits (high); line idles high.

---
 rtl/uart_tx.sv | 125 ++++++++++++
 tb/tb_uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, BIT_NUM data bits MSB first, STOP_BITS stop bits; line idles high.
// Latency 1 clock from accept to start bit; ready re-asserts in the final stop cycle.
module uart_tx #(
    parameter int CLK_CYCLES = 868,
    parameter int BIT_NUM    = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [BIT_NUM-1:0] i_tx_data,
    input  logic               i_tx_valid,
    output logic               o_tx_ready,
    output logic               o_tx_serial,
    output logic               o_tx_busy,
    output logic               o_tx_done
);

    localparam int CW = (CLK_CYCLES > 1) ? $clog2(CLK_CYCLES) : 1;
    localparam int IW = (BIT_NUM > 1) ? $clog2(BIT_NUM) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_CYCLES - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(CLK_CYCLES - 2);
    localparam logic [IW-1:0] IDX_MSB   = IW'(BIT_NUM - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q;
    logic [CW-1:0]      baud_q;
    logic [IW-1:0]      idx_q;
    logic               stop_q;
    logic [BIT_NUM-1:0] shift_q;
    logic               serial_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;

    logic          baud_wrap;
    logic [CW-1:0] baud_next;
    logic          last_stop;
    logic          accept;

    assign baud_wrap = (baud_q == BAUD_LAST);
    assign baud_next = baud_wrap ? '0 : baud_q + 1'b1;
    assign last_stop = (stop_q == STOP_LAST);
    assign accept    = i_tx_valid & ready_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (accept) begin
                        shift_q  <= i_tx_data;
                        state_q  <= START;
                        serial_q <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    baud_q <= baud_next;
                    if (baud_wrap) begin
                        state_q  <= DATA;
                        idx_q    <= IDX_MSB;
                        serial_q <= shift_q[IDX_MSB];
                    end
                end
                DATA: begin
                    baud_q <= baud_next;
                    if (baud_wrap) begin
                        if (idx_q == '0) begin
                            state_q  <= STOP;
                            stop_q   <= 1'b0;
                            serial_q <= 1'b1;
                        end else begin
                            idx_q    <= idx_q - 1'b1;
                            serial_q <= shift_q[idx_q - 1'b1];
                        end
                    end
                end
                STOP: begin
                    baud_q <= baud_next;
                    if (baud_wrap) begin
                        stop_q <= 1'b1;
                    end
                    // Outputs are registered, so ready/done are raised one cycle early
                    // to line up with the final stop cycle.
                    if (last_stop && (baud_q == BAUD_PRE)) begin
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                    if (last_stop && baud_wrap) begin
                        if (accept) begin
                            shift_q  <= i_tx_data;
                            state_q  <= START;
                            serial_q <= 1'b0;
                            ready_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_tx_serial = serial_q;
    assign o_tx_ready  = ready_q;
    assign o_tx_busy   = busy_q;
    assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (4 clk/bit 1 stop, 4 clk/bit 2 stop, 868 clk/bit 1 stop)
// driven with directed and random bytes; a monitor per instance checks each frame against a queue.
module tb_uart_tx;

    logic       clk;
    logic [2:0] rst;
    logic [2:0] vld;
    logic [7:0] dat [3];
    wire  [2:0] ser;
    wire  [2:0] rdy;
    wire  [2:0] busy;
    wire  [2:0] done;

    logic [7:0] expq [3][$];
    bit   [2:0] mon_act;
    bit         stop;
    int         checks;
    int         failures;

    uart_tx #(.CLK_CYCLES(4), .BIT_NUM(8), .STOP_BITS(1)) u_a (
        .i_clk(clk), .i_rst(rst[0]), .i_tx_data(dat[0]), .i_tx_valid(vld[0]),
        .o_tx_ready(rdy[0]), .o_tx_serial(ser[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));

    uart_tx #(.CLK_CYCLES(4), .BIT_NUM(8), .STOP_BITS(2)) u_b (
        .i_clk(clk), .i_rst(rst[1]), .i_tx_data(dat[1]), .i_tx_valid(vld[1]),
        .o_tx_ready(rdy[1]), .o_tx_serial(ser[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));

    uart_tx #(.CLK_CYCLES(868), .BIT_NUM(8), .STOP_BITS(1)) u_c (
        .i_clk(clk), .i_rst(rst[2]), .i_tx_data(dat[2]), .i_tx_valid(vld[2]),
        .o_tx_ready(rdy[2]), .o_tx_serial(ser[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int clk_of(input int id);
        return (id == 2) ? 868 : 4;
    endfunction

    function automatic int stops_of(input int id);
        return (id == 1) ? 2 : 1;
    endfunction

    // Line level during cycle k of a frame: bit slot k/cc is start, data MSB..LSB, then stop.
    function automatic logic exp_level(input logic [7:0] b, input int k, input int cc);
        int slot;
        slot = k / cc;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[8 - slot];
        return 1'b1;
    endfunction

    task automatic check(input string name, input int id, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0d expected=%0d at %0t", name, id, got, exp, $time);
        end
    endtask

    task automatic monitor(input int id);
        int         cc;
        int         flen;
        int         idle_n;
        int         idle_bad;
        int         bad_ser, bad_rdy, bad_busy, bad_done;
        bit         aborted;
        logic [7:0] b;
        logic [7:0] rx;
        cc       = clk_of(id);
        flen     = (9 + stops_of(id)) * cc;
        idle_n   = 0;
        idle_bad = 0;
        forever begin
            @(negedge clk);
            if (stop) break;
            if (expq[id].size() != 0) begin
                if (idle_n > 0) check("idle_outputs", id, idle_bad, 0);
                idle_n      = 0;
                idle_bad    = 0;
                b           = expq[id].pop_front();
                mon_act[id] = 1'b1;
                bad_ser = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
                aborted = 1'b0;
                rx      = 8'h00;
                for (int k = 0; k < flen; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst[id]) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (ser[id] !== exp_level(b, k, cc)) bad_ser++;
                    if (rdy[id] !== (k == flen - 1)) bad_rdy++;
                    if (busy[id] !== 1'b1) bad_busy++;
                    if (done[id] !== (k == flen - 1)) bad_done++;
                    if (k >= cc && k < 9 * cc && (k % cc) == cc / 2) rx = {rx[6:0], ser[id]};
                end
                check("frame_serial_bad_cycles", id, bad_ser, 0);
                check("frame_ready_bad_cycles", id, bad_rdy, 0);
                check("frame_busy_bad_cycles", id, bad_busy, 0);
                check("frame_done_bad_cycles", id, bad_done, 0);
                if (!aborted) check("rx_byte", id, int'(rx), int'(b));
                mon_act[id] = 1'b0;
            end else begin
                idle_n++;
                if (ser[id] !== 1'b1 || rdy[id] !== 1'b1 || busy[id] !== 1'b0 || done[id] !== 1'b0)
                    idle_bad++;
            end
        end
        if (idle_n > 0) check("idle_outputs", id, idle_bad, 0);
    endtask

    // Leaves valid high on return so a following send runs back-to-back.
    task automatic send(input int id, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        vld[id] = 1'b1;
        dat[id] = b;
        while (rdy[id] !== 1'b1) begin
            n++;
            if (n > 30000) begin
                check("accept_timeout", id, 0, 1);
                vld[id] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        expq[id].push_back(b);
    endtask

    task automatic idle(input int id, input int n);
        @(negedge clk);
        vld[id] = 1'b0;
        dat[id] = 8'($urandom);
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    task automatic drain(input int id);
        int n;
        n = 0;
        while ((expq[id].size() != 0 || mon_act[id] || busy[id] !== 1'b0) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30000) check("drain_timeout", id, 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic drv_a();
        idle(0, 5);
        send(0, 8'h81);
        send(0, 8'h7E);
        idle(0, 3);
        // A valid pulse mid-DATA must be ignored.
        send(0, 8'hC3);
        idle(0, 9);
        vld[0] = 1'b1;
        dat[0] = 8'h3C;
        idle(0, 2);
        drain(0);
        // Reset in the middle of data bit index 3 (a 0 bit of 0xA5).
        send(0, 8'hA5);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (21) @(posedge clk);
        #1 rst[0] = 1'b1;
        #1;
        check("rst_async_serial", 0, int'(ser[0]), 1);
        check("rst_async_ready", 0, int'(rdy[0]), 1);
        check("rst_async_busy", 0, int'(busy[0]), 0);
        check("rst_async_done", 0, int'(done[0]), 0);
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        idle(0, 3);
        send(0, 8'h55);
        idle(0, 2);
        for (int i = 0; i < 20; i++) begin
            send(0, 8'($urandom));
            if ($urandom_range(0, 2) != 0) idle(0, $urandom_range(1, 6));
        end
        idle(0, 1);
        drain(0);
    endtask

    task automatic drv_b();
        idle(1, 2);
        send(1, 8'hF0);
        idle(1, 2);
        for (int i = 0; i < 8; i++) begin
            send(1, 8'($urandom));
            if ($urandom_range(0, 1) != 0) idle(1, $urandom_range(1, 5));
        end
        idle(1, 1);
        drain(1);
    endtask

    task automatic drv_c();
        idle(2, 3000);
        send(2, 8'h65);
        send(2, 8'($urandom));
        idle(2, 1);
        drain(2);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        stop     = 1'b0;
        mon_act  = '0;
        rst      = 3'b111;
        vld      = 3'b000;
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_serial", i, int'(ser[i]), 1);
            check("reset_ready", i, int'(rdy[i]), 1);
            check("reset_busy", i, int'(busy[i]), 0);
            check("reset_done", i, int'(done[i]), 0);
        end
        repeat (3) @(negedge clk);
        rst = 3'b000;
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
        fork
            drv_a();
            drv_b();
            drv_c();
        join
        stop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
